// File: rtl/ttc_pkg.sv
// Shared types and constants for the truth-table self-test sequencer.
// The state encoding and vector count are common to the checker and its bench.
package ttc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } ttc_state_e;

    localparam logic [7:0] TTC_DEFAULT_MASK = 8'h3A;
    localparam int         TTC_NUM_VEC      = 8;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
// Intended for reuse by other self-test sequencers that need a hold interval.
module settle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all eight {x,y,z} vectors into a combinational block, samples F/Fn
// after a settle interval, and records per-vector failures against EXP_MASK.
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter logic [7:0]  EXP_MASK   = TTC_DEFAULT_MASK,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       f_in,
    input  logic       fn_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_map
);

    localparam logic [7:0] TIMER_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [2:0] LAST_IDX   = 3'(TTC_NUM_VEC - 1);

    ttc_state_e state_r;
    ttc_state_e next_state_s;
    logic [2:0] idx_r;
    logic [2:0] idx_next_s;
    logic       timer_load_s;
    logic       timer_en_s;
    logic       timer_zero_s;
    logic       exp_bit_s;
    logic       vec_fail_s;
    logic [3:0] err_cnt_next_s;
    logic [7:0] fail_map_next_s;
    logic       pass_next_s;
    logic       busy_next_s;
    logic [2:0] xyz_next_s;

    settle_timer #(
        .WIDTH (8)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .en       (timer_en_s),
        .load_val (TIMER_LOAD),
        .zero     (timer_zero_s)
    );

    // Next-state, compare and next-value logic for all result registers.
    always_comb begin
        next_state_s    = state_r;
        idx_next_s      = idx_r;
        timer_load_s    = 1'b0;
        timer_en_s      = 1'b0;
        err_cnt_next_s  = err_cnt;
        fail_map_next_s = fail_map;
        pass_next_s     = pass;
        exp_bit_s       = EXP_MASK[idx_r];
        // Fn must be the complement of F, so f_in == fn_in always fails.
        vec_fail_s      = (f_in != exp_bit_s) || (fn_in != ~exp_bit_s);

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    next_state_s    = SETTLE;
                    idx_next_s      = 3'd0;
                    timer_load_s    = 1'b1;
                    err_cnt_next_s  = 4'd0;
                    fail_map_next_s = 8'd0;
                    pass_next_s     = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            SETTLE: begin
                if (timer_zero_s) begin
                    next_state_s = SAMPLE;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            SAMPLE: begin
                if (vec_fail_s) begin
                    err_cnt_next_s  = err_cnt + 4'd1;
                    fail_map_next_s = fail_map | (8'd1 << idx_r);
                end else begin
                    err_cnt_next_s  = err_cnt;
                    fail_map_next_s = fail_map;
                end
                if (idx_r == LAST_IDX) begin
                    next_state_s = DONE;
                    pass_next_s  = (err_cnt_next_s == 4'd0);
                end else begin
                    next_state_s = SETTLE;
                    idx_next_s   = idx_r + 3'd1;
                    timer_load_s = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        busy_next_s = (next_state_s == SETTLE) || (next_state_s == SAMPLE);
        if (busy_next_s) begin
            xyz_next_s = idx_next_s;
        end else begin
            xyz_next_s = 3'd0;
        end
    end

    // State, index, result and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= 3'd0;
            err_cnt  <= 4'd0;
            fail_map <= 8'd0;
            pass     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x        <= 1'b0;
            y        <= 1'b0;
            z        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            idx_r       <= idx_next_s;
            err_cnt     <= err_cnt_next_s;
            fail_map    <= fail_map_next_s;
            pass        <= pass_next_s;
            busy        <= busy_next_s;
            done        <= (next_state_s == DONE);
            {x, y, z}   <= xyz_next_s;
        end
    end

endmodule
